// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD controller.
// Holds the state encoding, the power-up command ROM, word/status field positions and timing helpers.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_SETUP,
        ST_EN,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } lcd_state_t;

    localparam int INIT_LEN = 4;
    // Entry 0 sits in the low byte: function set, display on, clear, entry mode.
    localparam logic [INIT_LEN*8-1:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    localparam int DATA_MSB = 7;
    localparam int RS_BIT   = 8;
    localparam int ON_BIT   = 31;

    localparam int STAT_BUSY      = 31;
    localparam int STAT_OVERRUN   = 30;
    localparam int STAT_INIT_DONE = 29;
    localparam int STAT_PENDING   = 28;

    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_HOME_ALT = 8'h03;

    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear and home need the long execution wait; everything else uses the short one.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == OP_CLEAR || data == OP_HOME || data == OP_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_if.sv
// Store-side write port and LCD pin bundle of the LCD controller.
interface lcd_if;
    logic        i_wr_valid;
    logic [31:0] i_wr_word;
    logic        o_wr_ready;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic        o_lcd_on;
    logic [31:0] o_status;

    modport master (
        output i_wr_valid, i_wr_word,
        input  o_wr_ready, o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_status
    );

    modport slave (
        input  i_wr_valid, i_wr_word,
        output o_wr_ready, o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_status
    );
endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by all timed phases of the LCD controller.
// Loading value N (N >= 1) makes done rise in the N-th cycle counted from the load cycle.
module lcd_timer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= (value >= WIDTH'(2)) ? value - WIDTH'(2) : '0;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - WIDTH'(1);
        end
    end

    // The load cycle is the first cycle of the phase, so a length of 1 finishes immediately.
    assign done = load ? (value <= WIDTH'(1)) : (cnt_reg == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 LCD bus sequencer: power-up init, then one timed bus write per accepted store word.
// A single pending slot absorbs one store while the bus is busy; further stores are dropped and flagged.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 750_000,
    parameter int T_SETUP = 3,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 3,
    parameter int T_CMD   = 2_000,
    parameter int T_CLR   = 82_000
) (
    input logic  i_clk,
    input logic  i_rst,
    lcd_if.slave bus
);

    localparam int P_PWRUP = at_least_one(T_PWRUP);
    localparam int P_SETUP = at_least_one(T_SETUP);
    localparam int P_EN    = at_least_one(T_EN);
    localparam int P_HOLD  = at_least_one(T_HOLD);
    localparam int P_CMD   = at_least_one(T_CMD);
    localparam int P_CLR   = at_least_one(T_CLR);
    localparam int T_MAX   = max_int(max_int(max_int(P_PWRUP, P_SETUP), max_int(P_EN, P_HOLD)),
                                     max_int(P_CMD, P_CLR));
    localparam int TW      = max_int($clog2(T_MAX + 1), 2);

    localparam logic [TW-1:0] V_PWRUP = TW'(P_PWRUP);
    localparam logic [TW-1:0] V_SETUP = TW'(P_SETUP);
    localparam logic [TW-1:0] V_EN    = TW'(P_EN);
    localparam logic [TW-1:0] V_HOLD  = TW'(P_HOLD);
    localparam logic [TW-1:0] V_CMD   = TW'(P_CMD);
    localparam logic [TW-1:0] V_CLR   = TW'(P_CLR);

    lcd_state_t    state_reg;
    logic [2:0]    init_idx_reg;
    logic          load_reg;
    logic [TW-1:0] value_reg;
    logic          timer_done;
    logic          pend_valid_reg;
    logic [8:0]    pend_word_reg;
    logic          ready_reg;
    logic          overrun_reg;
    logic          init_done_reg;
    logic          busy_reg;
    logic [7:0]    lcd_data_reg;
    logic          lcd_rs_reg;
    logic          lcd_en_reg;
    logic          lcd_on_reg;

    logic          init_more;
    logic          wait_exit;
    logic          accept;
    logic          pop;
    logic          take_direct;
    logic          pend_valid_next;
    logic [8:0]    issue_word;
    logic          unused_word_bits;

    lcd_timer #(.WIDTH(TW)) u_timer (
        .clk   (i_clk),
        .srst  (i_rst),
        .load  (load_reg),
        .value (value_reg),
        .done  (timer_done)
    );

    // A word arriving exactly as the last WAIT expires with an empty slot bypasses the slot,
    // so it issues on the same edge it would have in IDLE.
    always_comb begin
        init_more       = (init_idx_reg != 3'(INIT_LEN));
        wait_exit       = (state_reg == ST_WAIT) && timer_done && !init_more;
        accept          = bus.i_wr_valid && ready_reg;
        pop             = wait_exit && pend_valid_reg;
        take_direct     = accept && ((state_reg == ST_IDLE) || (wait_exit && !pend_valid_reg));
        pend_valid_next = (pend_valid_reg && !pop) || (accept && !take_direct);
        issue_word      = pend_valid_reg ? pend_word_reg : bus.i_wr_word[RS_BIT:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= ST_PWRUP;
            init_idx_reg   <= '0;
            load_reg       <= 1'b1;
            value_reg      <= V_PWRUP;
            pend_valid_reg <= 1'b0;
            pend_word_reg  <= '0;
            ready_reg      <= 1'b1;
            overrun_reg    <= 1'b0;
            init_done_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            lcd_data_reg   <= '0;
            lcd_rs_reg     <= 1'b0;
            lcd_en_reg     <= 1'b0;
            lcd_on_reg     <= 1'b0;
        end else begin
            load_reg       <= 1'b0;
            busy_reg       <= 1'b1;
            pend_valid_reg <= pend_valid_next;
            ready_reg      <= !pend_valid_next;
            if (accept && !take_direct) pend_word_reg <= bus.i_wr_word[RS_BIT:0];
            if (accept) lcd_on_reg <= bus.i_wr_word[ON_BIT];
            if (bus.i_wr_valid && !ready_reg) overrun_reg <= 1'b1;

            case (state_reg)
                ST_PWRUP: begin
                    if (timer_done) state_reg <= ST_INIT;
                end
                ST_INIT: begin
                    lcd_data_reg <= INIT_ROM[{init_idx_reg[1:0], 3'b000} +: 8];
                    lcd_rs_reg   <= 1'b0;
                    init_idx_reg <= init_idx_reg + 3'd1;
                    state_reg    <= ST_SETUP;
                    load_reg     <= 1'b1;
                    value_reg    <= V_SETUP;
                end
                ST_SETUP: begin
                    if (timer_done) begin
                        lcd_en_reg <= 1'b1;
                        state_reg  <= ST_EN;
                        load_reg   <= 1'b1;
                        value_reg  <= V_EN;
                    end
                end
                ST_EN: begin
                    if (timer_done) begin
                        lcd_en_reg <= 1'b0;
                        state_reg  <= ST_HOLD;
                        load_reg   <= 1'b1;
                        value_reg  <= V_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (timer_done) begin
                        state_reg <= ST_WAIT;
                        load_reg  <= 1'b1;
                        value_reg <= is_slow_cmd(lcd_rs_reg, lcd_data_reg) ? V_CLR : V_CMD;
                    end
                end
                ST_WAIT: begin
                    if (timer_done) begin
                        if (init_more) begin
                            state_reg <= ST_INIT;
                        end else begin
                            init_done_reg <= 1'b1;
                            if (pop || take_direct) begin
                                lcd_data_reg <= issue_word[DATA_MSB:0];
                                lcd_rs_reg   <= issue_word[RS_BIT];
                                state_reg    <= ST_SETUP;
                                load_reg     <= 1'b1;
                                value_reg    <= V_SETUP;
                            end else begin
                                state_reg <= ST_IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end
                    end
                end
                ST_IDLE: begin
                    if (take_direct) begin
                        lcd_data_reg <= issue_word[DATA_MSB:0];
                        lcd_rs_reg   <= issue_word[RS_BIT];
                        state_reg    <= ST_SETUP;
                        load_reg     <= 1'b1;
                        value_reg    <= V_SETUP;
                    end else begin
                        busy_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.o_status                 = '0;
        bus.o_status[STAT_BUSY]      = busy_reg;
        bus.o_status[STAT_OVERRUN]   = overrun_reg;
        bus.o_status[STAT_INIT_DONE] = init_done_reg;
        bus.o_status[STAT_PENDING]   = pend_valid_reg;
    end

    assign bus.o_wr_ready = ready_reg;
    assign bus.o_lcd_data = lcd_data_reg;
    assign bus.o_lcd_rs   = lcd_rs_reg;
    assign bus.o_lcd_rw   = 1'b0;
    assign bus.o_lcd_en   = lcd_en_reg;
    assign bus.o_lcd_on   = lcd_on_reg;

    assign unused_word_bits = ^bus.i_wr_word[ON_BIT-1:RS_BIT+1];

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: a transaction-level timing model predicts every EN pulse,
// acceptance decision and busy-release edge; a separate monitor checks what the bus shows.
module tb_lcd_ctrl;

    localparam int TP   = 20;
    localparam int TS   = 2;
    localparam int TE   = 4;
    localparam int TH   = 2;
    localparam int TCMD = 10;
    localparam int TCLR = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_if bus();

    lcd_ctrl #(
        .T_PWRUP (TP),
        .T_SETUP (TS),
        .T_EN    (TE),
        .T_HOLD  (TH),
        .T_CMD   (TCMD),
        .T_CLR   (TCLR)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         rise;
    } exp_t;

    exp_t sb[$];
    int   last_end;
    int   last_a;
    int   last_e;
    bit   have_last;
    bit   exp_overrun;
    bit   exp_on;
    logic [7:0] init_rom [4];

    // A bus write spans setup + enable + hold + execution wait; clear/home wait longer.
    function automatic int dur(input logic rs, input logic [7:0] d);
        int w;
        w = (!rs && d >= 8'd1 && d <= 8'd3) ? TCLR : TCMD;
        return TS + TE + TH + w;
    endfunction

    // r = index of the last clock edge sampled with reset high.
    task automatic model_reset(input int r);
        int   t;
        exp_t x;
        sb.delete();
        t = r + TP + 1;
        for (int k = 0; k < 4; k++) begin
            x.data = init_rom[k];
            x.rs   = 1'b0;
            x.rise = t + TS;
            sb.push_back(x);
            t += dur(1'b0, init_rom[k]);
            if (k < 3) t += 1;
        end
        last_end    = t;
        have_last   = 1'b0;
        exp_overrun = 1'b0;
        exp_on      = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] w);
        int   t;
        int   e;
        bit   rdy;
        exp_t x;
        t   = cyc + 1;
        rdy = !(have_last && last_a < t && t <= last_e);
        check("wr_ready", 32'(bus.o_wr_ready), 32'(rdy));
        bus.i_wr_valid = 1'b1;
        bus.i_wr_word  = w;
        if (rdy) begin
            e      = (t > last_end) ? t : last_end;
            x.data = w[7:0];
            x.rs   = w[8];
            x.rise = e + TS;
            sb.push_back(x);
            last_end  = e + dur(w[8], w[7:0]);
            have_last = 1'b1;
            last_a    = t;
            last_e    = e;
            exp_on    = w[31];
        end else begin
            exp_overrun = 1'b1;
        end
        $display("write 0x%08h at edge %0d %s", w, t, rdy ? "accepted" : "dropped");
        step();
        bus.i_wr_valid = 1'b0;
        check("lcd_on", 32'(bus.o_lcd_on), 32'(exp_on));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (cyc <= last_end + 2 && n < 3000) begin
            step();
            n++;
        end
        check("drain_in_time", 32'(cyc > last_end + 2), 32'd1);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) begin
            w[8]   = 1'b0;
            w[7:0] = 8'($urandom_range(1, 3));
        end
        return w;
    endfunction

    // ---------------- monitor ----------------
    bit   prev_en;
    bit   prev_busy;
    int   en_len;
    exp_t mon_x;

    initial begin
        prev_en   = 1'b0;
        prev_busy = 1'b0;
        en_len    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en   = 1'b0;
                prev_busy = 1'b0;
                en_len    = 0;
            end else begin
                if (bus.o_lcd_en && !prev_en) begin
                    check("expected_pulse_queued", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        mon_x = sb.pop_front();
                        $display("lcd pulse data 0x%02h rs %0d at edge %0d", bus.o_lcd_data, bus.o_lcd_rs, cyc);
                        check("pulse_data", 32'(bus.o_lcd_data), 32'(mon_x.data));
                        check("pulse_rs", 32'(bus.o_lcd_rs), 32'(mon_x.rs));
                        check("pulse_rise_edge", cyc, mon_x.rise);
                        check("busy_in_tx", 32'(bus.o_status[31]), 32'd1);
                    end
                end
                if (bus.o_lcd_en) en_len++;
                if (!bus.o_lcd_en && prev_en) begin
                    check("en_width", en_len, TE);
                    en_len = 0;
                end
                if (!bus.o_status[31] && prev_busy) begin
                    check("busy_release_edge", cyc, last_end);
                    check("init_done_at_idle", 32'(bus.o_status[29]), 32'd1);
                end
                prev_en   = bus.o_lcd_en;
                prev_busy = bus.o_status[31];
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        init_rom = '{8'h38, 8'h0C, 8'h01, 8'h06};
        bus.i_wr_valid = 1'b0;
        bus.i_wr_word  = '0;
        repeat (3) @(negedge clk);
        check("rst_status", bus.o_status, 32'h0);
        check("rst_ready", 32'(bus.o_wr_ready), 32'd1);
        check("rst_en", 32'(bus.o_lcd_en), 32'd0);
        check("rst_data", 32'(bus.o_lcd_data), 32'd0);
        check("rst_rs_rw_on", 32'({bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_on}), 32'd0);
        #1 rst = 1'b0;
        model_reset(cyc);

        // power-up init sequence
        drain();
        check("status_after_init", bus.o_status, 32'h2000_0000);

        // single data write from idle
        do_write(32'h8000_0141);
        check("data_next_cycle", 32'(bus.o_lcd_data), 32'h41);
        check("rs_next_cycle", 32'(bus.o_lcd_rs), 32'd1);
        drain();

        // back-to-back pair: second waits in the slot
        do_write(32'h0000_0141);
        do_write(32'h0000_0142);
        check("pending_flag", 32'(bus.o_status[28]), 32'd1);
        drain();
        check("no_overrun_pair", 32'(bus.o_status[30]), 32'(exp_overrun));

        // three in a row: third is dropped
        do_write(32'h0000_0143);
        do_write(32'h0000_0144);
        do_write(32'h0000_0145);
        drain();
        check("overrun_sticky", 32'(bus.o_status[30]), 32'(exp_overrun));

        // clear uses the long wait, RS=1 with the same byte uses the short one
        do_write(32'h0000_0001);
        drain();
        do_write(32'h0000_0101);
        drain();

        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(0, 30);
            repeat (n) step();
            do_write(rand_word());
        end
        drain();
        check("status_after_random", bus.o_status, {1'b0, exp_overrun, 1'b1, 1'b0, 28'h0});
        check("scoreboard_empty", sb.size(), 0);

        // reset in the middle of an enable pulse
        do_write(32'h0000_0148);
        n = 0;
        while (!bus.o_lcd_en && n < 500) begin
            step();
            n++;
        end
        check("en_seen_before_reset", 32'(bus.o_lcd_en), 32'd1);
        rst = 1'b1;
        step();
        check("reset_en", 32'(bus.o_lcd_en), 32'd0);
        check("reset_status", bus.o_status, 32'h0);
        check("reset_ready", 32'(bus.o_wr_ready), 32'd1);
        rst = 1'b0;
        model_reset(cyc);
        repeat (5) step();
        do_write(rand_word());
        drain();
        check("status_final", bus.o_status, 32'h2000_0000);
        check("scoreboard_empty_final", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
